// File: rtl/mips_pkg.sv
// Shared datapath constants and types for the MIPS register-file side blocks.
// Consumed by dec3to8 and demux8_reg.
package mips_pkg;

   localparam int WORD_W  = 32;
   localparam int SEL_W   = 3;
   localparam int NUM_ENT = 8;
   localparam int BE_W    = WORD_W / 8;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [WORD_W-1:0] word_t;

endpackage : mips_pkg

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable: onehot = en ? (1 << sel) : 0.
module dec3to8
   import mips_pkg::*;
(
   input  logic               en,
   input  sel_t               sel,
   output logic [NUM_ENT-1:0] onehot
);

   // NOTE: default first so every path assigns onehot and no latch is inferred.
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[sel] = 1'b1;
      end
   end

endmodule : dec3to8

// File: rtl/demux8_reg.sv
// Registered 1-to-8 write distributor with byte enables, valid bits and write ack.
// Define DEMUX8_ZERO_ENTRY_EN to hardwire entry 0 to zero (always valid, writes dropped).
module demux8_reg
   import mips_pkg::*;
#(
   parameter int WIDTH   = WORD_W,
   parameter int NUM_OUT = NUM_ENT
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  sel_t               wr_sel,
   input  logic [WIDTH-1:0]   wr_data,
   input  logic [WIDTH/8-1:0] wr_be,
   input  logic               clr_en,
   input  logic [NUM_ENT-1:0] clr_mask,
   output logic [WIDTH-1:0]   out_0,
   output logic [WIDTH-1:0]   out_1,
   output logic [WIDTH-1:0]   out_2,
   output logic [WIDTH-1:0]   out_3,
   output logic [WIDTH-1:0]   out_4,
   output logic [WIDTH-1:0]   out_5,
   output logic [WIDTH-1:0]   out_6,
   output logic [WIDTH-1:0]   out_7,
   output logic [NUM_ENT-1:0] valid,
   output logic               wr_ack,
   output sel_t               wr_ack_sel
);

   localparam int LANES = WIDTH / 8;

`ifdef DEMUX8_ZERO_ENTRY_EN
   localparam bit ZERO_ENTRY = 1'b1;
`else
   localparam bit ZERO_ENTRY = 1'b0;
`endif

   localparam logic [NUM_ENT-1:0] VALID_RST = ZERO_ENTRY ? NUM_ENT'(1) : '0;

   logic [NUM_ENT-1:0] wr_strobe;
   logic [WIDTH-1:0]   entry_q [NUM_ENT];
   logic [WIDTH-1:0]   entry_d [NUM_ENT];
   logic [NUM_ENT-1:0] valid_q, valid_d;
   logic [NUM_ENT-1:0] clr_vec, set_vec;
   logic               ack_q, ack_d;
   sel_t               ack_sel_q, ack_sel_d;

   dec3to8 u_wr_dec (
      .en     (wr_en),
      .sel    (wr_sel),
      .onehot (wr_strobe)
   );

   // Byte-lane merge: only the strobed entry's enabled lanes take new data.
   always_comb begin
      for (int k = 0; k < NUM_ENT; k++) begin
         entry_d[k] = entry_q[k];
         for (int b = 0; b < LANES; b++) begin
            if (wr_strobe[k] && wr_be[b]) begin
               entry_d[k][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
      if (ZERO_ENTRY) begin
         entry_d[0] = '0;
      end
   end

   // Set terms are OR-ed after the clear so a same-entry write wins.
   always_comb begin
      clr_vec = clr_en ? clr_mask : '0;
      set_vec = (|wr_be) ? wr_strobe : '0;
      valid_d = (valid_q & ~clr_vec) | set_vec;
      if (ZERO_ENTRY) begin
         valid_d[0] = 1'b1;
      end
   end

   always_comb begin
      ack_d     = wr_en;
      ack_sel_d = wr_en ? wr_sel : ack_sel_q;
   end

   // NOTE: the entry array is reset explicitly because outputs must read zero
   // after reset; state updates use non-blocking assignments throughout.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_ENT; k++) begin
            entry_q[k] <= '0;
         end
         valid_q   <= VALID_RST;
         ack_q     <= 1'b0;
         ack_sel_q <= '0;
      end else begin
         for (int k = 0; k < NUM_ENT; k++) begin
            entry_q[k] <= entry_d[k];
         end
         valid_q   <= valid_d;
         ack_q     <= ack_d;
         ack_sel_q <= ack_sel_d;
      end
   end

   assign out_0      = entry_q[0];
   assign out_1      = entry_q[1];
   assign out_2      = entry_q[2];
   assign out_3      = entry_q[3];
   assign out_4      = entry_q[4];
   assign out_5      = entry_q[5];
   assign out_6      = entry_q[6];
   assign out_7      = entry_q[7];
   assign valid      = valid_q;
   assign wr_ack     = ack_q;
   assign wr_ack_sel = ack_sel_q;

endmodule : demux8_reg
